fft_pipe_ctrl: RTL

- Flow controller for the FFT datapath's register pipeline. The datapath is a chain of NSTAGE stall-enabled data registers.
- Tracks a valid bit per stage and generates each stage's stall so bubbles collapse under output backpressure.
- Counts samples per N-point frame and flags frame boundaries at input and output.
- Sits between the sample source and the butterfly pipeline; the datapath registers are driven only by this block's stall vector.

---
 rtl/fft_pipe_ctrl_if.sv | 27 ++
 rtl/fft_pipe_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/fft_pipe_ctrl_if.sv
// fft_pipe_ctrl_if: sample handshake bundle between the source/sink side and
// the FFT pipeline flow controller.
//   master : the side that presents samples and accepts results (source/sink)
//   slave  : the flow controller itself
interface fft_pipe_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_last;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_last
  );
endinterface

// File: rtl/fft_pipe_ctrl.sv
// fft_pipe_ctrl: flow controller for the FFT datapath register chain.
// Keeps one valid bit per pipeline stage and drives each stage's stall so that
// empty stages keep loading under output backpressure (bubbles collapse).
// Counts samples per N = 2**LOG2N frame on the input and output sides and
// flags frame boundaries.
// Optional build macro FFT_PIPE_CTRL_PERF_EN adds a 16-bit saturating counter
// (stall_cnt) of cycles where the source was held off.
module fft_pipe_ctrl #(
  parameter int NSTAGE = 8,
  parameter int LOG2N  = 6
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clr,
  fft_pipe_ctrl_if.slave      bus,
  output logic [NSTAGE-1:0]   stall,
  output logic [NSTAGE-1:0]   vld,
  output logic [LOG2N-1:0]    in_idx,
  output logic                frame_start,
  output logic                frame_done,
  output logic                busy
`ifdef FFT_PIPE_CTRL_PERF_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  logic [NSTAGE-1:0] adv;
  logic [NSTAGE-1:0] vld_shift;
  logic [LOG2N-1:0]  out_idx;
  logic              in_hs;
  logic              out_hs;

  // Advance chain: a stage may load when it is empty or everything downstream moves.
  always_comb begin
    logic chain;
    // NOTE: combinational blocks use blocking '=' and assign every output first,
    // so no path leaves a value unassigned and no latch is inferred.
    adv   = '0;
    chain = !vld[NSTAGE-1] || bus.out_ready;
    adv[NSTAGE-1] = chain;
    for (int i = NSTAGE - 2; i >= 0; i--) begin
      chain  = !vld[i] || chain;
      adv[i] = chain;
    end
  end

  // Valid bit each stage would receive if it loads: its predecessor's, or the source's.
  always_comb begin
    vld_shift    = vld << 1;
    vld_shift[0] = bus.in_valid;
  end

  assign stall         = ~adv;
  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld[NSTAGE-1];
  assign bus.out_last  = vld[NSTAGE-1] && (out_idx == '1);

  assign in_hs       = bus.in_valid && adv[0];
  assign out_hs      = vld[NSTAGE-1] && bus.out_ready;
  assign frame_start = in_hs && (in_idx == '0);
  assign busy        = (|vld) || (|in_idx);

  // Per-stage valid bits: loading stages take the upstream bit, stalled stages hold.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state is updated with non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    if (!n_rst) begin
      vld <= '0;
    end else if (clr) begin
      vld <= '0;
    end else begin
      vld <= (vld & ~adv) | (vld_shift & adv);
    end
  end

  // Frame position counters; N is a power of two so they wrap by overflow.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_idx  <= '0;
      out_idx <= '0;
    end else if (clr) begin
      in_idx  <= '0;
      out_idx <= '0;
    end else begin
      if (in_hs)  in_idx  <= in_idx + 1'b1;
      if (out_hs) out_idx <= out_idx + 1'b1;
    end
  end

  // One-cycle pulse following the handshake of the last sample of a frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_done <= 1'b0;
    end else if (clr) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_hs && bus.out_last;
    end
  end

`ifdef FFT_PIPE_CTRL_PERF_EN
  // Saturating count of cycles where a presented sample was refused.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt <= '0;
    end else if (clr) begin
      stall_cnt <= '0;
    end else if (bus.in_valid && !adv[0] && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
